// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model answering INCR read/write bursts from a word array.
// Each completed write burst is followed by a line-aligned AC snoop (when SNOOP_EN).
module axi_mem_responder #(
  parameter int ID_WIDTH     = 13,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 4096,
  parameter int READ_LATENCY = 2,
  parameter int LINE_BYTES   = 128,
  parameter int SNOOP_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,

  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,

  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,

  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,

  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,

  output logic                  s_axi_acvalid,
  input  logic                  s_axi_acready,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int OFFW = $clog2(STRB_WIDTH);
  localparam int IDXW = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [3:0] SNOOP_INVALIDATE = 4'hD;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rdState_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_SNOOP, W_RESP} wrState_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  rdState_e              rdState_q;
  logic                  arReady_q;
  logic [ID_WIDTH-1:0]   rdId_q;
  logic [IDXW-1:0]       rdAddr_q;
  logic [7:0]            rdLen_q;
  logic [7:0]            rdBeat_q;
  logic [3:0]            rdLat_q;
  logic                  rValid_q;
  logic                  rLast_q;
  logic [DATA_WIDTH-1:0] rData_q;
  logic [IDXW-1:0]       rdAddrNext_d;

  wrState_e              wrState_q;
  logic                  awReady_q;
  logic                  wReady_q;
  logic [ADDR_WIDTH-1:0] wrStart_q;
  logic [IDXW-1:0]       wrAddr_q;
  logic [7:0]            wrLen_q;
  logic [7:0]            wrBeat_q;
  logic                  wrErr_q;
  logic [ID_WIDTH-1:0]   bId_q;
  logic [1:0]            bResp_q;
  logic                  bValid_q;
  logic                  acValid_q;
  logic [ADDR_WIDTH-1:0] acAddr_q;
  logic [3:0]            acSnoop_q;

  logic                  wFire_d;
  logic                  wLastExp_d;
  logic                  wrErr_d;
  logic [DATA_WIDTH-1:0] wMerged_d;

  // Upper address bits deliberately alias onto the array.
  logic unused_araddr;
  assign unused_araddr = ^s_axi_araddr;

  assign rdAddrNext_d = rdAddr_q + IDXW'(1);

  assign wFire_d    = (wrState_q == W_DATA) && wReady_q && s_axi_wvalid;
  assign wLastExp_d = (wrBeat_q == wrLen_q);
  assign wrErr_d    = wrErr_q | (s_axi_wlast != wLastExp_d);

  always_comb begin
    wMerged_d = mem[wrAddr_q];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (s_axi_wstrb[b]) wMerged_d[b*8 +: 8] = s_axi_wdata[b*8 +: 8];
    end
  end

  // The array is intentionally left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wFire_d) mem[wrAddr_q] <= wMerged_d;
  end

  // Read FSM: fetches the next word into rData_q only when a beat is accepted,
  // so the R payload stays frozen while rready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdState_q <= R_IDLE;
      arReady_q <= 1'b0;
      rdId_q    <= '0;
      rdAddr_q  <= '0;
      rdLen_q   <= '0;
      rdBeat_q  <= '0;
      rdLat_q   <= '0;
      rValid_q  <= 1'b0;
      rLast_q   <= 1'b0;
      rData_q   <= '0;
    end else begin
      unique case (rdState_q)
        R_IDLE: begin
          arReady_q <= 1'b1;
          if (s_axi_arvalid && arReady_q) begin
            arReady_q <= 1'b0;
            rdId_q    <= s_axi_arid;
            rdAddr_q  <= s_axi_araddr[OFFW +: IDXW];
            rdLen_q   <= s_axi_arlen;
            rdBeat_q  <= '0;
            if (READ_LATENCY == 0) begin
              rdState_q <= R_DATA;
            end else begin
              rdState_q <= R_WAIT;
              rdLat_q   <= 4'(READ_LATENCY - 1);
            end
          end
        end
        R_WAIT: begin
          if (rdLat_q == 4'd0) rdState_q <= R_DATA;
          else                 rdLat_q   <= rdLat_q - 4'd1;
        end
        R_DATA: begin
          if (!rValid_q) begin
            rValid_q <= 1'b1;
            rData_q  <= mem[rdAddr_q];
            rLast_q  <= (rdLen_q == 8'd0);
          end else if (s_axi_rready) begin
            if (rLast_q) begin
              rValid_q  <= 1'b0;
              rLast_q   <= 1'b0;
              arReady_q <= 1'b1;
              rdState_q <= R_IDLE;
            end else begin
              rdAddr_q <= rdAddrNext_d;
              rdBeat_q <= rdBeat_q + 8'd1;
              rData_q  <= mem[rdAddrNext_d];
              rLast_q  <= ((rdBeat_q + 8'd1) == rdLen_q);
            end
          end
        end
        default: rdState_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: the burst length alone ends the data phase; a misplaced wlast
  // only flags SLVERR in the final response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrState_q <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      wrStart_q <= '0;
      wrAddr_q  <= '0;
      wrLen_q   <= '0;
      wrBeat_q  <= '0;
      wrErr_q   <= 1'b0;
      bId_q     <= '0;
      bResp_q   <= 2'b00;
      bValid_q  <= 1'b0;
      acValid_q <= 1'b0;
      acAddr_q  <= '0;
      acSnoop_q <= '0;
    end else begin
      unique case (wrState_q)
        W_IDLE: begin
          awReady_q <= 1'b1;
          if (s_axi_awvalid && awReady_q) begin
            awReady_q <= 1'b0;
            wReady_q  <= 1'b1;
            wrStart_q <= s_axi_awaddr;
            wrAddr_q  <= s_axi_awaddr[OFFW +: IDXW];
            wrLen_q   <= s_axi_awlen;
            wrBeat_q  <= '0;
            wrErr_q   <= 1'b0;
            bId_q     <= s_axi_awid;
            wrState_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wFire_d) begin
            wrErr_q  <= wrErr_d;
            wrAddr_q <= wrAddr_q + IDXW'(1);
            wrBeat_q <= wrBeat_q + 8'd1;
            if (wLastExp_d) begin
              wReady_q <= 1'b0;
              if (SNOOP_EN != 0) begin
                acValid_q <= 1'b1;
                acAddr_q  <= wrStart_q & LINE_MASK;
                acSnoop_q <= SNOOP_INVALIDATE;
                wrState_q <= W_SNOOP;
              end else begin
                bValid_q  <= 1'b1;
                bResp_q   <= wrErr_d ? 2'b10 : 2'b00;
                wrState_q <= W_RESP;
              end
            end
          end
        end
        W_SNOOP: begin
          if (s_axi_acready) begin
            acValid_q <= 1'b0;
            bValid_q  <= 1'b1;
            bResp_q   <= wrErr_q ? 2'b10 : 2'b00;
            wrState_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wrState_q <= W_IDLE;
          end
        end
        default: wrState_q <= W_IDLE;
      endcase
    end
  end

  assign s_axi_arready = arReady_q;
  assign s_axi_rid     = rdId_q;
  assign s_axi_rdata   = rData_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rLast_q;
  assign s_axi_rvalid  = rValid_q;

  assign s_axi_awready = awReady_q;
  assign s_axi_wready  = wReady_q;
  assign s_axi_bid     = bId_q;
  assign s_axi_bresp   = bResp_q;
  assign s_axi_bvalid  = bValid_q;
  assign s_axi_acvalid = acValid_q;
  assign s_axi_acaddr  = acAddr_q;
  assign s_axi_acsnoop = acSnoop_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single-beat vector table followed by
// hand-written burst, latency, backpressure, wlast-error and reset sequences.
module tb_axi_mem_responder;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;

  logic [IDW-1:0] s_axi_awid = '0;
  logic [AW-1:0]  s_axi_awaddr = '0;
  logic [7:0]     s_axi_awlen = '0;
  logic           s_axi_awvalid = 1'b0;
  logic           s_axi_awready;
  logic [DW-1:0]  s_axi_wdata = '0;
  logic [SW-1:0]  s_axi_wstrb = '0;
  logic           s_axi_wlast = 1'b0;
  logic           s_axi_wvalid = 1'b0;
  logic           s_axi_wready;
  logic [IDW-1:0] s_axi_bid;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_bvalid;
  logic           s_axi_bready = 1'b0;
  logic [IDW-1:0] s_axi_arid = '0;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           s_axi_acvalid;
  logic           s_axi_acready = 1'b0;
  logic [AW-1:0]  s_axi_acaddr;
  logic [3:0]     s_axi_acsnoop;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .MEM_WORDS(4096), .READ_LATENCY(2), .LINE_BYTES(128), .SNOOP_EN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready),
    .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop)
  );

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [63:0] wdArr  [256];
  logic [7:0]  wsArr  [256];
  logic        wlArr  [256];
  logic [63:0] expArr [256];

  typedef struct {
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] raddr;
    logic [63:0] expAc;
    logic [63:0] expRead;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic awPhase(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
    int k = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id; s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && k < 100) begin @(negedge clk); k++; end
    if (!s_axi_awready) checkOutput("awready timeout", 64'(s_axi_awready), 64'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic arPhase(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
    int k = 0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && k < 100) begin @(negedge clk); k++; end
    if (!s_axi_arready) checkOutput("arready timeout", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wBeats(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      s_axi_wdata = wdArr[i]; s_axi_wstrb = wsArr[i]; s_axi_wlast = wlArr[i];
      s_axi_wvalid = 1'b1;
      @(negedge clk);
      while (!s_axi_wready && k < 100) begin @(negedge clk); k++; end
      if (!s_axi_wready) checkOutput("wready timeout", 64'(i), 64'(n));
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic finishWrite(input logic [63:0] expAc, input logic [IDW-1:0] expId, input logic [1:0] expResp);
    int k = 0;
    @(negedge clk);
    while (!s_axi_acvalid && k < 100) begin @(negedge clk); k++; end
    checkOutput("acvalid", 64'(s_axi_acvalid), 64'd1);
    checkOutput("acaddr", s_axi_acaddr, expAc);
    checkOutput("acsnoop", 64'(s_axi_acsnoop), 64'hD);
    s_axi_acready = 1'b1;
    @(posedge clk); #1;
    s_axi_acready = 1'b0;
    k = 0;
    @(negedge clk);
    while (!s_axi_bvalid && k < 100) begin @(negedge clk); k++; end
    checkOutput("bvalid", 64'(s_axi_bvalid), 64'd1);
    checkOutput("bid", 64'(s_axi_bid), 64'(expId));
    checkOutput("bresp", 64'(s_axi_bresp), 64'(expResp));
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    checkOutput("awready after B", 64'(s_axi_awready), 64'd1);
  endtask

  // Collects n beats of a burst of length len+1, comparing every cycle rvalid is
  // high (stalled cycles included) against expArr; bp selects rready 1,0,0,1.
  task automatic rCollect(input int n, input int len, input logic [IDW-1:0] id, input bit bp, output int cycles);
    int beat = 0;
    cycles = 0;
    while (beat < n && cycles < 300) begin
      s_axi_rready = bp ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (s_axi_rvalid) begin
        checkOutput($sformatf("rdata beat %0d", beat), s_axi_rdata, expArr[beat]);
        checkOutput($sformatf("rlast beat %0d", beat), 64'(s_axi_rlast), 64'(beat == len));
        checkOutput("rid", 64'(s_axi_rid), 64'(id));
        checkOutput("rresp", 64'(s_axi_rresp), 64'd0);
        if (s_axi_rready) beat++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    s_axi_rready = 1'b0;
    if (beat < n) checkOutput("read beats timeout", 64'(beat), 64'(n));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cyc;
    awPhase(v.waddr, 8'd0, IDW'(idx + 1));
    wdArr[0] = v.wdata; wsArr[0] = v.wstrb; wlArr[0] = 1'b1;
    wBeats(1);
    finishWrite(v.expAc, IDW'(idx + 1), 2'b00);
    arPhase(v.raddr, 8'd0, IDW'(idx + 20));
    expArr[0] = v.expRead;
    rCollect(1, 0, IDW'(idx + 20), 1'b0, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int k;

    vecs[0] = '{64'h2008, 64'h0, 8'hFF, 64'h2008, 64'h2000, 64'h0};
    vecs[1] = '{64'h2008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h2008, 64'h2000, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{64'h3010, 64'h1122_3344_5566_7788, 8'hFF, 64'h3010, 64'h3000, 64'h1122_3344_5566_7788};
    vecs[3] = '{64'h3010, 64'hAAAA_AAAA_AAAA_AAAA, 8'hA0, 64'h3010, 64'h3000, 64'hAA22_AA44_5566_7788};
    vecs[4] = '{64'hB010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h3010, 64'hB000, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{64'h7FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'h7FF8, 64'h7F80, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[6] = '{64'hFFFF_0000_0000_2010, 64'h5A5A_5A5A_0000_1111, 8'hFF, 64'h2010,
                64'hFFFF_0000_0000_2000, 64'h5A5A_5A5A_0000_1111};

    repeat (3) @(negedge clk);
    checkOutput("reset awready", 64'(s_axi_awready), 64'd0);
    checkOutput("reset arready", 64'(s_axi_arready), 64'd0);
    checkOutput("reset rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("reset bvalid", 64'(s_axi_bvalid), 64'd0);
    checkOutput("reset acvalid", 64'(s_axi_acvalid), 64'd0);
    checkOutput("reset wready", 64'(s_axi_wready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready after release", 64'(s_axi_awready), 64'd1);
    checkOutput("arready after release", 64'(s_axi_arready), 64'd1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    $display("[TB] write burst 0x1000 len 15");
    awPhase(64'h1000, 8'd15, IDW'(3));
    for (int i = 0; i < 16; i++) begin
      wdArr[i] = 64'h1000 + 64'(i); wsArr[i] = 8'hFF; wlArr[i] = (i == 15);
    end
    wBeats(16);
    finishWrite(64'h1000, IDW'(3), 2'b00);

    $display("[TB] read burst latency and back-to-back beats");
    for (int i = 0; i < 16; i++) expArr[i] = 64'h1000 + 64'(i);
    arPhase(64'h1000, 8'd15, IDW'(5));
    k = 0;
    while (!s_axi_rvalid && k < 20) begin @(posedge clk); #1; k++; end
    checkOutput("read latency edges", 64'(k), 64'd3);
    rCollect(16, 15, IDW'(5), 1'b0, cyc);
    checkOutput("back-to-back cycles", 64'(cyc), 64'd16);
    checkOutput("arready after last beat", 64'(s_axi_arready), 64'd1);
    checkOutput("rvalid after last beat", 64'(s_axi_rvalid), 64'd0);

    $display("[TB] read backpressure");
    arPhase(64'h1000, 8'd7, IDW'(6));
    rCollect(8, 7, IDW'(6), 1'b1, cyc);

    $display("[TB] wlast mismatch");
    awPhase(64'h4000, 8'd3, IDW'(7));
    for (int i = 0; i < 4; i++) begin
      wdArr[i] = 64'h40 + 64'(i); wsArr[i] = 8'hFF; wlArr[i] = (i == 1) || (i == 3);
      expArr[i] = 64'h40 + 64'(i);
    end
    wBeats(4);
    finishWrite(64'h4000, IDW'(7), 2'b10);
    arPhase(64'h4000, 8'd3, IDW'(13));
    rCollect(4, 3, IDW'(13), 1'b0, cyc);

    $display("[TB] index wrap at array end");
    awPhase(64'h7FF8, 8'd1, IDW'(8));
    wdArr[0] = 64'h77; wdArr[1] = 64'h88; wsArr[0] = 8'hFF; wsArr[1] = 8'hFF;
    wlArr[0] = 1'b0; wlArr[1] = 1'b1;
    wBeats(2);
    finishWrite(64'h7F80, IDW'(8), 2'b00);
    expArr[0] = 64'h77; expArr[1] = 64'h88;
    arPhase(64'h7FF8, 8'd1, IDW'(14));
    rCollect(2, 1, IDW'(14), 1'b0, cyc);

    $display("[TB] simultaneous AW and AR");
    s_axi_awaddr = 64'h5000; s_axi_awlen = 8'd0; s_axi_awid = IDW'(11); s_axi_awvalid = 1'b1;
    s_axi_araddr = 64'h1008; s_axi_arlen = 8'd0; s_axi_arid = IDW'(12); s_axi_arvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(s_axi_awready && s_axi_arready) && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    checkOutput("dual accept awready", 64'(s_axi_awready), 64'd0);
    checkOutput("dual accept arready", 64'(s_axi_arready), 64'd0);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    wdArr[0] = 64'h5555; wsArr[0] = 8'hFF; wlArr[0] = 1'b1;
    wBeats(1);
    finishWrite(64'h5000, IDW'(11), 2'b00);
    expArr[0] = 64'h1001;
    rCollect(1, 0, IDW'(12), 1'b0, cyc);

    $display("[TB] reset in the middle of a read burst");
    for (int i = 0; i < 16; i++) expArr[i] = 64'h1000 + 64'(i);
    arPhase(64'h1000, 8'd15, IDW'(9));
    rCollect(5, 15, IDW'(9), 1'b0, cyc);
    #1 reset = 1'b0;
    #1;
    checkOutput("rvalid in reset", 64'(s_axi_rvalid), 64'd0);
    checkOutput("arready in reset", 64'(s_axi_arready), 64'd0);
    checkOutput("rdata in reset", s_axi_rdata, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("arready after mid-burst reset", 64'(s_axi_arready), 64'd1);
    arPhase(64'h1000, 8'd3, IDW'(10));
    rCollect(4, 3, IDW'(10), 1'b0, cyc);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
